// File: rtl/divider_stream_ctrl.sv
// divider_stream_ctrl: streams tagged divide requests through a divider IP and returns the results in issue order under a credit limit
// Ports:
//   clk, rst                    clock and synchronous active-high reset (also drives the IP's aresetn = ~rst)
//   in_valid/in_ready/in_*      request stream: signed divisor, signed dividend, user tag
//   s_axis_divisor_*            divisor operand channel to the IP
//   s_axis_dividend_*           dividend operand channel to the IP
//   m_axis_dout_*               IP result channel (non-blocking, no tready)
//   result_*                    in-order result stream with tag and divide-by-zero flag
//   busy                        at least one accepted op has not yet been popped
//   protocol_err                sticky: the IP produced a result with no op outstanding
module divider_stream_ctrl #(
   parameter int DOUT_TDATA_WIDTH     = 48,
   parameter int DIVISOR_TDATA_WIDTH  = 32,
   parameter int DIVIDEND_TDATA_WIDTH = 32,
   parameter int TAG_WIDTH            = 4,
   parameter int MAX_OUTSTANDING      = 4,
   parameter int ZERO_CHECK           = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DIVISOR_TDATA_WIDTH-1:0]  in_divisor,
   input  logic [DIVIDEND_TDATA_WIDTH-1:0] in_dividend,
   input  logic [TAG_WIDTH-1:0]            in_tag,
   output logic [DIVISOR_TDATA_WIDTH-1:0]  s_axis_divisor_tdata,
   output logic                            s_axis_divisor_tvalid,
   input  logic                            s_axis_divisor_tready,
   output logic [DIVIDEND_TDATA_WIDTH-1:0] s_axis_dividend_tdata,
   output logic                            s_axis_dividend_tvalid,
   input  logic                            s_axis_dividend_tready,
   input  logic [DOUT_TDATA_WIDTH-1:0]     m_axis_dout_tdata,
   input  logic                            m_axis_dout_tvalid,
   output logic [DOUT_TDATA_WIDTH-1:0]     result_data,
   output logic [TAG_WIDTH-1:0]            result_tag,
   output logic                            result_dbz,
   output logic                            result_valid,
   input  logic                            result_ready,
   output logic                            busy,
   output logic                            protocol_err
);
   localparam int AW = $clog2(MAX_OUTSTANDING);
   localparam int CW = AW + 1;
   logic [CW-1:0] credits, pend;
   logic [AW-1:0] tw, tr;
   logic [AW:0] rw, rr;
   logic [TAG_WIDTH:0] tag_mem [MAX_OUTSTANDING];
   logic [DOUT_TDATA_WIDTH-1:0] res_mem [MAX_OUTSTANDING];
   logic acc, pop, stray, got, dbz;
   // the issue register is empty once neither channel still holds a tvalid
   assign in_ready = (credits != '0) && !s_axis_divisor_tvalid && !s_axis_dividend_tvalid;
   assign acc = in_valid && in_ready;
   assign result_valid = rw != rr;
   assign pop = result_valid && result_ready;
   // pend counts ops accepted but not yet answered by the IP; a result with none pending is dropped
   assign stray = m_axis_dout_tvalid && (pend == '0);
   assign got = m_axis_dout_tvalid && !stray;
   assign dbz = (ZERO_CHECK != 0) && (in_divisor == '0);
   assign {result_tag, result_dbz} = tag_mem[tr];
   assign result_data = result_dbz ? '0 : res_mem[rr[AW-1:0]];
   assign busy = credits != CW'(MAX_OUTSTANDING);
   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CW'(MAX_OUTSTANDING);
         pend <= '0;
         tw <= '0;
         tr <= '0;
         rw <= '0;
         rr <= '0;
         s_axis_divisor_tvalid <= 1'b0;
         s_axis_dividend_tvalid <= 1'b0;
         s_axis_divisor_tdata <= '0;
         s_axis_dividend_tdata <= '0;
         protocol_err <= 1'b0;
      end else begin
         credits <= credits - CW'(acc) + CW'(pop);
         pend <= pend + CW'(acc) - CW'(got);
         tw <= tw + AW'(acc);
         tr <= tr + AW'(pop);
         rw <= rw + CW'(got);
         rr <= rr + CW'(pop);
         // each channel drops its tvalid independently once its own tready is seen
         s_axis_divisor_tvalid <= acc || (s_axis_divisor_tvalid && !s_axis_divisor_tready);
         s_axis_dividend_tvalid <= acc || (s_axis_dividend_tvalid && !s_axis_dividend_tready);
         s_axis_divisor_tdata <= acc ? in_divisor : s_axis_divisor_tdata;
         s_axis_dividend_tdata <= acc ? in_dividend : s_axis_dividend_tdata;
         protocol_err <= protocol_err || stray;
      end
   end
   always_ff @(posedge clk) begin
      if (acc) tag_mem[tw] <= {in_tag, dbz};
      if (got) res_mem[rw[AW-1:0]] <= m_axis_dout_tdata;
   end
endmodule

// File: tb/tb_divider_stream_ctrl.sv
// tb_divider_stream_ctrl: randomized and directed bench for divider_stream_ctrl against an in-bench behavioural model and IP emulation
module tb_divider_stream_ctrl;
   localparam int DW = 48;
   localparam int TW = 4;
   localparam int MO = 4;
   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready;
   logic [31:0] in_divisor, in_dividend;
   logic [TW-1:0] in_tag;
   logic [31:0] s_axis_divisor_tdata, s_axis_dividend_tdata;
   logic s_axis_divisor_tvalid, s_axis_divisor_tready, s_axis_dividend_tvalid, s_axis_dividend_tready;
   logic [DW-1:0] m_axis_dout_tdata;
   logic m_axis_dout_tvalid;
   logic [DW-1:0] result_data;
   logic [TW-1:0] result_tag;
   logic result_dbz, result_valid, result_ready, busy, protocol_err;

   always #5 clk = ~clk;

   divider_stream_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_divisor(in_divisor), .in_dividend(in_dividend), .in_tag(in_tag),
      .s_axis_divisor_tdata(s_axis_divisor_tdata), .s_axis_divisor_tvalid(s_axis_divisor_tvalid), .s_axis_divisor_tready(s_axis_divisor_tready),
      .s_axis_dividend_tdata(s_axis_dividend_tdata), .s_axis_dividend_tvalid(s_axis_dividend_tvalid), .s_axis_dividend_tready(s_axis_dividend_tready),
      .m_axis_dout_tdata(m_axis_dout_tdata), .m_axis_dout_tvalid(m_axis_dout_tvalid),
      .result_data(result_data), .result_tag(result_tag), .result_dbz(result_dbz), .result_valid(result_valid), .result_ready(result_ready),
      .busy(busy), .protocol_err(protocol_err)
   );

   typedef struct { logic [TW-1:0] tag; logic dbz; logic [DW-1:0] data; } exp_t;
   exp_t exp_q[$];
   logic [DW-1:0] ip_data_q[$];
   int ip_due_q[$];
   logic [31:0] hs_dvs[$], hs_dvd[$];
   int used, avail, outstanding, cyc, lat, last_due, total, bad, acc_cnt, pop_cnt;
   bit div_pend, dvd_pend, perr, armed, inject;
   logic [31:0] div_val, dvd_val;
   logic [DW-1:0] last_data;
   logic [TW-1:0] last_tag;
   logic last_dbz;

   // stand-in for the divider IP: signed quotient, arbitrary marker when dividing by zero
   function automatic logic [DW-1:0] ip_func(logic [31:0] a, logic [31:0] b);
      longint q;
      if (b == 0) return 48'hABC_DEF0_1234;
      q = longint'($signed(a)) / longint'($signed(b));
      return q[DW-1:0];
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input bit r, input bit iv, input logic [31:0] dvs, input logic [31:0] dvd,
                       input logic [TW-1:0] tg, input bit vtr, input bit dtr, input bit rr);
      bit exp_ir, acc, pop;
      int due;
      @(negedge clk);
      cyc++;
      exp_ir = used < MO && !div_pend && !dvd_pend;
      if (armed) begin
         chk("in_ready", in_ready, exp_ir);
         chk("busy", busy, used != 0);
         chk("protocol_err", protocol_err, perr);
         chk("divisor_tvalid", s_axis_divisor_tvalid, div_pend);
         chk("dividend_tvalid", s_axis_dividend_tvalid, dvd_pend);
         if (div_pend) chk("divisor_tdata", s_axis_divisor_tdata, div_val);
         if (dvd_pend) chk("dividend_tdata", s_axis_dividend_tdata, dvd_val);
         chk("result_valid", result_valid, avail > 0);
         if (avail > 0 && exp_q.size() > 0) begin
            chk("result_tag", result_tag, exp_q[0].tag);
            chk("result_dbz", result_dbz, exp_q[0].dbz);
            chk("result_data", result_data, exp_q[0].data);
         end
      end
      rst = r; in_valid = iv; in_divisor = dvs; in_dividend = dvd; in_tag = tg;
      s_axis_divisor_tready = vtr; s_axis_dividend_tready = dtr; result_ready = rr;
      m_axis_dout_tvalid = 1'b0; m_axis_dout_tdata = '0;
      if (!r && ip_due_q.size() > 0 && ip_due_q[0] <= cyc) begin
         m_axis_dout_tvalid = 1'b1;
         m_axis_dout_tdata = ip_data_q.pop_front();
         void'(ip_due_q.pop_front());
      end else if (!r && inject) begin
         m_axis_dout_tvalid = 1'b1;
         m_axis_dout_tdata = 48'h5A5A;
         inject = 0;
      end
      if (r) begin
         exp_q.delete(); ip_data_q.delete(); ip_due_q.delete(); hs_dvs.delete(); hs_dvd.delete();
         used = 0; avail = 0; outstanding = 0; div_pend = 0; dvd_pend = 0; perr = 0; last_due = -1;
         armed = 1;
      end else begin
         pop = rr && avail > 0;
         acc = iv && exp_ir;
         if (m_axis_dout_tvalid) begin
            if (outstanding == 0) perr = 1;
            else begin outstanding--; avail++; end
         end
         if (div_pend && vtr) begin div_pend = 0; hs_dvs.push_back(div_val); end
         if (dvd_pend && dtr) begin dvd_pend = 0; hs_dvd.push_back(dvd_val); end
         if (pop) begin
            last_data = result_data; last_tag = result_tag; last_dbz = result_dbz;
            void'(exp_q.pop_front()); avail--; used--; pop_cnt++;
         end
         if (acc) begin
            used++; outstanding++; acc_cnt++;
            exp_q.push_back('{tag: tg, dbz: dvs == 0, data: dvs == 0 ? '0 : ip_func(dvd, dvs)});
            div_pend = 1; dvd_pend = 1; div_val = dvs; dvd_val = dvd;
         end
         while (hs_dvs.size() > 0 && hs_dvd.size() > 0) begin
            logic [31:0] a, b;
            a = hs_dvd.pop_front();
            b = hs_dvs.pop_front();
            ip_data_q.push_back(ip_func(a, b));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ip_due_q.push_back(due);
         end
      end
   endtask

   task automatic idle(input bit rr);
      step(0, 0, 0, 0, 0, 1, 1, rr);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (used != 0 || div_pend || dvd_pend); i++) idle(1);
      chk("drain_credits", used, 0);
   endtask

   initial begin
      int a0, p0, n, dvc, ddc;
      rst = 1; in_valid = 0; in_divisor = 0; in_dividend = 0; in_tag = 0;
      s_axis_divisor_tready = 0; s_axis_dividend_tready = 0; result_ready = 0;
      m_axis_dout_tvalid = 0; m_axis_dout_tdata = 0;
      total = 0; bad = 0; cyc = 0; lat = 10; acc_cnt = 0; pop_cnt = 0; armed = 0; inject = 0; last_due = -1;
      used = 0; avail = 0; outstanding = 0; div_pend = 0; dvd_pend = 0; perr = 0;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_result_valid", result_valid, 0);
      chk("reset_tvalids", {s_axis_divisor_tvalid, s_axis_dividend_tvalid}, 0);
      // single op 100 / 7, tag 3, IP latency 10
      p0 = pop_cnt;
      step(0, 1, 7, 100, 3, 1, 1, 1);
      for (int i = 0; i < 40 && pop_cnt == p0; i++) idle(1);
      chk("single_pops", pop_cnt - p0, 1);
      chk("single_data", last_data, 14);
      chk("single_tag", last_tag, 3);
      chk("single_dbz", last_dbz, 0);
      idle(1);
      chk("single_busy_after", busy, 0);
      // back-to-back tags 0..7 with short IP latency
      lat = 2; a0 = acc_cnt; p0 = pop_cnt;
      for (int i = 0; i < 16; i++) begin
         n = acc_cnt - a0;
         step(0, n < 8, 32'(n + 1), 32'(n * 50 - 77), TW'(n), 1, 1, 1);
      end
      chk("b2b_accepts", acc_cnt - a0, 8);
      drain();
      chk("b2b_pops", pop_cnt - p0, 8);
      chk("b2b_last_tag", last_tag, 7);
      // credit stall: 6 requests with result_ready low
      lat = 3; a0 = acc_cnt; p0 = pop_cnt;
      for (int i = 0; i < 20; i++) step(0, acc_cnt - a0 < 6, 32'(i + 2), 32'(i * 1000), TW'(acc_cnt - a0), 1, 1, 0);
      chk("stall_accepts", acc_cnt - a0, 4);
      chk("stall_in_ready", in_ready, 0);
      for (int i = 0; i < 60 && pop_cnt - p0 < 6; i++) step(0, acc_cnt - a0 < 6, 32'(i + 3), 32'(-i * 9), TW'(acc_cnt - a0), 1, 1, 1);
      chk("stall_total_accepts", acc_cnt - a0, 6);
      chk("stall_total_pops", pop_cnt - p0, 6);
      drain();
      // skewed tready: divisor tready held off for three cycles
      lat = 4; a0 = acc_cnt; dvc = 0; ddc = 0;
      step(0, 1, 32'd13, 32'd1300, 4'd5, 0, 1, 1);
      for (int i = 0; i < 6; i++) begin
         step(0, i < 4, 32'd3, 32'd9, 4'd6, i >= 3, 1, 1);
         dvc += int'(s_axis_divisor_tvalid);
         ddc += int'(s_axis_dividend_tvalid);
      end
      chk("skew_divisor_cycles", dvc, 4);
      chk("skew_dividend_cycles", ddc, 1);
      chk("skew_accepts", acc_cnt - a0, 1);
      drain();
      // divide by zero
      p0 = pop_cnt;
      step(0, 1, 0, -32'sd5, 4'd9, 1, 1, 1);
      drain();
      chk("dbz_pops", pop_cnt - p0, 1);
      chk("dbz_data", last_data, 0);
      chk("dbz_flag", last_dbz, 1);
      chk("dbz_tag", last_tag, 9);
      // reset with three ops in flight, then a spurious IP result
      lat = 10; a0 = acc_cnt;
      for (int i = 0; i < 8; i++) step(0, acc_cnt - a0 < 3, 32'(i + 1), 32'(i + 40), TW'(i), 1, 1, 0);
      chk("inflight_busy", busy, 1);
      step(1, 0, 0, 0, 0, 1, 1, 0);
      idle(0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_result_valid", result_valid, 0);
      inject = 1;
      idle(1);
      idle(1);
      chk("spurious_protocol_err", protocol_err, 1);
      chk("spurious_result_valid", result_valid, 0);
      for (int i = 0; i < 15; i++) idle(1);
      chk("sticky_protocol_err", protocol_err, 1);
      step(1, 0, 0, 0, 0, 1, 1, 1);
      idle(1);
      chk("rst_clears_protocol_err", protocol_err, 0);
      // randomized traffic over several IP latencies
      for (int ph = 0; ph < 4; ph++) begin
         lat = $urandom_range(1, 12);
         for (int i = 0; i < 400; i++) begin
            logic [31:0] dv;
            dv = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) != 0 ? 32'($urandom_range(1, 20)) : $urandom);
            step(0, $urandom_range(0, 3) != 0, dv, $urandom, TW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
         end
         drain();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
